param_counter: RTL and testbench

PARAM_COUNTER -- requirements
Module: param_counter

---
 rtl/param_counter_pkg.sv | 19 +
 rtl/param_counter_tick.sv | 36 +++
 rtl/param_counter.sv | 146 ++++++++++++++
 tb/tb_param_counter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/param_counter_pkg.sv
// Shared types and constants for the parameterised up/down/bounce counter.
// Mode encoding matches the mode_i port bit patterns.
package param_counter_pkg;

   localparam int unsigned MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_UP     = 2'b00,
      MODE_DOWN   = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_HOLD   = 2'b11
   } cnt_mode_e;

   // Minimum of two unsigned values of equal width, used for clamped loads.
   function automatic logic [31:0] umin32(input logic [31:0] a, input logic [31:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/param_counter_tick.sv
// Prescaler for param_counter: emits a one-cycle step tick on every
// PRESCALE-th enabled cycle and freezes while en_i is low.
module tick_gen #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pcnt;
   logic          at_last;

   assign at_last = (pcnt == LAST);
   assign tick_o  = en_i && at_last;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcnt <= '0;
      end else if (clr_i) begin
         pcnt <= '0;
      end else if (en_i) begin
         if (at_last) begin
            pcnt <= '0;
         end else begin
            pcnt <= pcnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/param_counter.sv
// Parameterised counter with up, down, bounce and hold modes, saturate or
// wrap boundary policy, clamped load, terminal-count pulse and sticky flag.
module param_counter
   import param_counter_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned PRESCALE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en_i,
   input  logic              clear_i,
   input  logic              load_i,
   input  logic [WIDTH-1:0]  load_val_i,
   input  logic [MODE_W-1:0] mode_i,
   input  logic              sat_i,
   input  logic [WIDTH-1:0]  max_i,
   output logic [WIDTH-1:0]  cnt_o,
   output logic              dir_o,
   output logic              tc_o,
   output logic              ovf_o
);

   logic             tick;
   logic             restart;
   cnt_mode_e        mode;

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             boundary;

   logic             below_max;
   logic             above_zero;
   logic             max_zero;
   logic [WIDTH-1:0] load_clamped;

   // Clear and load both restart the prescaler so the next step is a full interval away.
   assign restart = clear_i | load_i;
   assign mode    = cnt_mode_e'(mode_i);

   tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick (
      .clk    (clk),
      .reset  (reset),
      .en_i   (en_i),
      .clr_i  (restart),
      .tick_o (tick)
   );

   assign below_max    = (cnt_q < max_i);
   assign above_zero   = (cnt_q != '0);
   assign max_zero     = (max_i == '0);
   assign load_clamped = (load_val_i < max_i) ? load_val_i : max_i;

   always_comb begin
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      tc_d     = 1'b0;
      ovf_d    = ovf_q;
      boundary = 1'b0;

      if (clear_i) begin
         cnt_d = '0;
         dir_d = 1'b1;
         ovf_d = 1'b0;
      end else if (load_i) begin
         cnt_d = load_clamped;
      end else if (tick) begin
         unique case (mode)
            MODE_UP: begin
               dir_d = 1'b1;
               if (below_max) begin
                  cnt_d = cnt_q + 1'b1;
               end else begin
                  boundary = 1'b1;
                  cnt_d    = sat_i ? max_i : '0;
               end
            end
            MODE_DOWN: begin
               dir_d = 1'b0;
               if (above_zero) begin
                  cnt_d = cnt_q - 1'b1;
               end else begin
                  boundary = 1'b1;
                  cnt_d    = sat_i ? '0 : max_i;
               end
            end
            MODE_BOUNCE: begin
               // At a limit the flip and the reverse step happen in the same tick;
               // an over-range count is pulled back to max_i-1 on the way down.
               if (dir_q) begin
                  if (below_max) begin
                     cnt_d = cnt_q + 1'b1;
                  end else begin
                     boundary = 1'b1;
                     dir_d    = 1'b0;
                     cnt_d    = max_zero ? '0 : max_i - 1'b1;
                  end
               end else begin
                  if (above_zero) begin
                     cnt_d = cnt_q - 1'b1;
                  end else begin
                     boundary = 1'b1;
                     dir_d    = 1'b1;
                     cnt_d    = max_zero ? '0 : WIDTH'(1);
                  end
               end
            end
            MODE_HOLD: begin
               cnt_d = cnt_q;
            end
            default: begin
               cnt_d = cnt_q;
            end
         endcase

         if (boundary) begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         dir_q <= 1'b1;
         tc_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         dir_q <= dir_d;
         tc_q  <= tc_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt_o = cnt_q;
   assign dir_o = dir_q;
   assign tc_o  = tc_q;
   assign ovf_o = ovf_q;

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: two instances (PRESCALE 1 and 4) share stimulus
// and are compared each cycle against an integer reference model.
module tb_param_counter;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             reset;
   logic             en_i;
   logic             clear_i;
   logic             load_i;
   logic [WIDTH-1:0] load_val_i;
   logic [1:0]       mode_i;
   logic             sat_i;
   logic [WIDTH-1:0] max_i;

   logic [WIDTH-1:0] cnt1, cnt4;
   logic             dir1, dir4, tc1, tc4, ovf1, ovf4;

   int checks = 0;
   int fails  = 0;

   // Reference model state, index 0 -> PRESCALE 1, index 1 -> PRESCALE 4
   int m_cnt [2];
   int m_dir [2];
   int m_tc  [2];
   int m_ovf [2];
   int m_pre [2];
   int m_p   [2] = '{1, 4};

   param_counter #(.WIDTH(WIDTH), .PRESCALE(1)) dut1 (
      .clk(clk), .reset(reset), .en_i(en_i), .clear_i(clear_i), .load_i(load_i),
      .load_val_i(load_val_i), .mode_i(mode_i), .sat_i(sat_i), .max_i(max_i),
      .cnt_o(cnt1), .dir_o(dir1), .tc_o(tc1), .ovf_o(ovf1)
   );

   param_counter #(.WIDTH(WIDTH), .PRESCALE(4)) dut4 (
      .clk(clk), .reset(reset), .en_i(en_i), .clear_i(clear_i), .load_i(load_i),
      .load_val_i(load_val_i), .mode_i(mode_i), .sat_i(sat_i), .max_i(max_i),
      .cnt_o(cnt4), .dir_o(dir4), .tc_o(tc4), .ovf_o(ovf4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = 0; m_dir[k] = 1; m_tc[k] = 0; m_ovf[k] = 0; m_pre[k] = 0;
      end
   endtask

   // Apply one rising edge worth of behaviour using the inputs currently driven.
   task automatic model_update();
      int mx, c, d, ev, tick;
      mx = int'(max_i);
      for (int k = 0; k < 2; k++) begin
         if (!reset) begin
            m_cnt[k] = 0; m_dir[k] = 1; m_tc[k] = 0; m_ovf[k] = 0; m_pre[k] = 0;
         end else if (clear_i) begin
            m_cnt[k] = 0; m_dir[k] = 1; m_tc[k] = 0; m_ovf[k] = 0; m_pre[k] = 0;
         end else if (load_i) begin
            m_cnt[k] = (int'(load_val_i) < mx) ? int'(load_val_i) : mx;
            m_pre[k] = 0;
            m_tc[k]  = 0;
         end else begin
            tick = 0;
            if (en_i) begin
               m_pre[k]++;
               if (m_pre[k] == m_p[k]) begin
                  tick = 1;
                  m_pre[k] = 0;
               end
            end
            c = m_cnt[k]; d = m_dir[k]; ev = 0;
            if (tick && mode_i != 2'd3) begin
               case (mode_i)
                  2'd0: begin
                     d = 1;
                     if (c < mx) c = c + 1;
                     else begin ev = 1; c = sat_i ? mx : 0; end
                  end
                  2'd1: begin
                     d = 0;
                     if (c > 0) c = c - 1;
                     else begin ev = 1; c = sat_i ? 0 : mx; end
                  end
                  default: begin
                     if (d == 1) begin
                        if (c < mx) c = c + 1;
                        else begin ev = 1; d = 0; c = (mx > 0) ? mx - 1 : 0; end
                     end else begin
                        if (c > 0) c = c - 1;
                        else begin ev = 1; d = 1; c = (mx > 0) ? 1 : 0; end
                     end
                  end
               endcase
            end
            m_cnt[k] = c;
            m_dir[k] = d;
            m_tc[k]  = ev;
            if (ev == 1) m_ovf[k] = 1;
         end
      end
   endtask

   task automatic check_all();
      chk("cnt_p1", 32'(cnt1), m_cnt[0]);
      chk("dir_p1", 32'(dir1), m_dir[0]);
      chk("tc_p1",  32'(tc1),  m_tc[0]);
      chk("ovf_p1", 32'(ovf1), m_ovf[0]);
      chk("cnt_p4", 32'(cnt4), m_cnt[1]);
      chk("dir_p4", 32'(dir4), m_dir[1]);
      chk("tc_p4",  32'(tc4),  m_tc[1]);
      chk("ovf_p4", 32'(ovf4), m_ovf[1]);
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle_inputs();
      en_i = 1'b0; clear_i = 1'b0; load_i = 1'b0; load_val_i = '0;
      mode_i = 2'd0; sat_i = 1'b0; max_i = 8'd255;
   endtask

   initial begin
      int npulse;
      logic [7:0] seq_c [5];
      logic       seq_t [5];
      logic [7:0] bexp [7];
      logic       bdir [7];
      reset = 1'b0;
      idle_inputs();
      model_reset();
      @(negedge clk);
      step();
      chk("reset_cnt", 32'(cnt1), 0);
      chk("reset_dir", 32'(dir1), 1);
      reset = 1'b1;
      step();

      // Free-running wrap over the full 8-bit range
      en_i = 1'b1; mode_i = 2'd0; sat_i = 1'b0; max_i = 8'd255;
      npulse = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (tc1 === 1'b1) npulse++;
      end
      chk("wrap_tc_pulses", 32'(npulse), 1);
      chk("wrap_cnt_end", 32'(cnt1), 44);
      chk("wrap_ovf", 32'(ovf1), 1);

      // Saturating down count from a load of 3
      clear_i = 1'b1; step(); clear_i = 1'b0;
      mode_i = 2'd1; sat_i = 1'b1; load_i = 1'b1; load_val_i = 8'd3;
      step();
      load_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         seq_c[i] = cnt1; seq_t[i] = tc1;
      end
      chk("down_sat_c0", 32'(seq_c[0]), 2);
      chk("down_sat_c2", 32'(seq_c[2]), 0);
      chk("down_sat_c4", 32'(seq_c[4]), 0);
      chk("down_sat_t2", 32'(seq_t[2]), 0);
      chk("down_sat_t3", 32'(seq_t[3]), 1);
      chk("down_sat_t4", 32'(seq_t[4]), 1);

      // Bounce between 0 and 3
      clear_i = 1'b1; step(); clear_i = 1'b0;
      mode_i = 2'd2; max_i = 8'd3;
      bexp = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1};
      bdir = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 7; i++) begin
         step();
         chk("bounce_cnt", 32'(cnt1), 32'(bexp[i]));
         chk("bounce_dir", 32'(dir1), 32'(bdir[i]));
      end

      // Prescaled stepping with an enable gap
      clear_i = 1'b1; step(); clear_i = 1'b0;
      mode_i = 2'd0; max_i = 8'd255;
      for (int i = 0; i < 3; i++) step();
      chk("pre4_before", 32'(cnt4), 0);
      step();
      chk("pre4_first", 32'(cnt4), 1);
      for (int i = 0; i < 2; i++) step();
      en_i = 1'b0;
      for (int i = 0; i < 3; i++) step();
      en_i = 1'b1;
      step();
      chk("pre4_gap_hold", 32'(cnt4), 1);
      step();
      chk("pre4_gap_step", 32'(cnt4), 2);

      // Clear beats load beats tick; clamped load
      clear_i = 1'b1; load_i = 1'b1; load_val_i = 8'd77; step();
      chk("clr_over_load", 32'(cnt1), 0);
      clear_i = 1'b0; max_i = 8'd100; load_val_i = 8'd200; step();
      chk("load_clamp", 32'(cnt1), 100);
      load_i = 1'b0;

      // Asynchronous reset mid-bounce at count 5
      clear_i = 1'b1; max_i = 8'd10; step(); clear_i = 1'b0;
      mode_i = 2'd2;
      for (int i = 0; i < 5; i++) step();
      chk("pre_reset_cnt", 32'(cnt1), 5);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_cnt", 32'(cnt1), 0);
      chk("async_rst_dir", 32'(dir1), 1);
      chk("async_rst_tc",  32'(tc1),  0);
      chk("async_rst_ovf", 32'(ovf1), 0);
      chk("async_rst_cnt4", 32'(cnt4), 0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      step();
      chk("resume_cnt", 32'(cnt1), 1);
      chk("resume_dir", 32'(dir1), 1);

      // Randomised traffic against the reference model
      for (int i = 0; i < 2000; i++) begin
         clear_i    = ($urandom_range(0, 99) < 3);
         load_i     = ($urandom_range(0, 99) < 5);
         load_val_i = 8'($urandom_range(0, 255));
         en_i       = ($urandom_range(0, 99) < 80);
         if ($urandom_range(0, 99) < 10) mode_i = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 99) < 10) sat_i  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 99) < 5) begin
            case ($urandom_range(0, 4))
               0: max_i = 8'd0;
               1: max_i = 8'd1;
               2: max_i = 8'd3;
               3: max_i = 8'd255;
               default: max_i = 8'($urandom_range(0, 255));
            endcase
         end
         step();
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
